collision_engine: RTL

Frame-rate collision engine for the pong datapath, generalising the two-paddle combinational detector to NUM_PADDLES paddles plus playfield walls and goals. On each frame strobe it snapshots ball and paddle positions, then scans paddles one per cycle through a single shared comparator. It reports a prioritised hit with bounce flags, and applies a post-hit cooldown so a single contact produces exactly one paddle bounce. It sits between the position registers and the ball-motion block, which consumes `result_valid` and the flip flags.

---
 rtl/collision_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/collision_engine.sv
//----------------------------------------------------------------------------
// Module      : collision_engine
// Description : Frame-rate ball/paddle/wall collision engine with a single
//               shared paddle comparator, lowest-index priority and cooldown.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module collision_engine #(
  parameter int BIT_WIDTH     = 10,
  parameter int BALL_RADIUS   = 4,
  parameter int PADDLE_WIDTH  = 4,
  parameter int PADDLE_LENGTH = 32,
  parameter int NUM_PADDLES   = 2,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int PROXIMITY     = 2,
  parameter int COOLDOWN      = 4,
  localparam int IDX_W        = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic [BIT_WIDTH-1:0]           ball_x,
  input  logic [BIT_WIDTH-1:0]           ball_y,
  input  logic [NUM_PADDLES*BIT_WIDTH-1:0] paddle_x,
  input  logic [NUM_PADDLES*BIT_WIDTH-1:0] paddle_y,
  output logic                           busy,
  output logic                           result_valid,
  output logic                           paddle_hit,
  output logic [IDX_W-1:0]               paddle_idx,
  output logic [NUM_PADDLES-1:0]         touching,
  output logic                           wall_top,
  output logic                           wall_bottom,
  output logic                           goal_left,
  output logic                           goal_right,
  output logic                           flip_x,
  output logic                           flip_y,
  output logic                           overrun
);

  localparam int SW   = BIT_WIDTH + 2;
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic signed [SW-1:0]  c_XLIM   = SW'(PADDLE_WIDTH + BALL_RADIUS + PROXIMITY);
  localparam logic signed [SW-1:0]  c_YLEN   = SW'(PADDLE_LENGTH);
  localparam logic [BIT_WIDTH-1:0]  c_TOP    = BIT_WIDTH'(BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0]  c_BOTTOM = BIT_WIDTH'(SCREEN_H - 1 - BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0]  c_LEFT   = BIT_WIDTH'(BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0]  c_RIGHT  = BIT_WIDTH'(SCREEN_W - 1 - BALL_RADIUS);
  localparam logic [IDX_W-1:0]      c_LAST   = IDX_W'(NUM_PADDLES - 1);
  localparam logic [CD_W-1:0]       c_CD     = CD_W'(COOLDOWN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_WALLS  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t                           r_state;
  logic [IDX_W-1:0]                 r_idx;
  logic [IDX_W-1:0]                 r_cand;
  logic                             r_any;
  logic [NUM_PADDLES-1:0]           r_touch_acc;
  logic [3:0]                       r_wall_acc;
  logic [CD_W-1:0]                  r_cd;
  logic [BIT_WIDTH-1:0]             r_bx;
  logic [BIT_WIDTH-1:0]             r_by;
  logic [NUM_PADDLES*BIT_WIDTH-1:0] r_pxs;
  logic [NUM_PADDLES*BIT_WIDTH-1:0] r_pys;

  logic [BIT_WIDTH-1:0] w_px_arr [NUM_PADDLES];
  logic [BIT_WIDTH-1:0] w_py_arr [NUM_PADDLES];

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_unpack
    assign w_px_arr[g] = r_pxs[g*BIT_WIDTH +: BIT_WIDTH];
    assign w_py_arr[g] = r_pys[g*BIT_WIDTH +: BIT_WIDTH];
  end

  // Shared comparator; zero-extended signed math keeps py - LENGTH from wrapping.
  logic signed [SW-1:0] w_bx_s, w_by_s, w_px_s, w_py_s, w_dx, w_adx;
  logic                 w_contact;

  always_comb begin
    w_bx_s    = $signed({2'b00, r_bx});
    w_by_s    = $signed({2'b00, r_by});
    w_px_s    = $signed({2'b00, w_px_arr[r_idx]});
    w_py_s    = $signed({2'b00, w_py_arr[r_idx]});
    w_dx      = w_bx_s - w_px_s;
    w_adx     = w_dx[SW-1] ? -w_dx : w_dx;
    w_contact = (w_adx <= c_XLIM) &&
                (w_by_s >= (w_py_s - c_YLEN)) &&
                (w_by_s <= (w_py_s + c_YLEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cand       <= '0;
      r_any        <= 1'b0;
      r_touch_acc  <= '0;
      r_wall_acc   <= '0;
      r_cd         <= '0;
      r_bx         <= '0;
      r_by         <= '0;
      r_pxs        <= '0;
      r_pys        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      paddle_hit   <= 1'b0;
      paddle_idx   <= '0;
      touching     <= '0;
      wall_top     <= 1'b0;
      wall_bottom  <= 1'b0;
      goal_left    <= 1'b0;
      goal_right   <= 1'b0;
      flip_x       <= 1'b0;
      flip_y       <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (frame_tick && (r_state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_bx        <= ball_x;
            r_by        <= ball_y;
            r_pxs       <= paddle_x;
            r_pys       <= paddle_y;
            r_touch_acc <= '0;
            r_any       <= 1'b0;
            r_cand      <= '0;
            r_idx       <= '0;
            busy        <= 1'b1;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_touch_acc[r_idx] <= w_contact;
          if (w_contact && !r_any) begin
            r_any  <= 1'b1;
            r_cand <= r_idx;
          end
          if (r_idx == c_LAST) begin
            r_state <= S_WALLS;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_WALLS: begin
          r_wall_acc <= {r_by <= c_TOP, r_by >= c_BOTTOM, r_bx <= c_LEFT, r_bx >= c_RIGHT};
          r_state    <= S_REPORT;
        end
        S_REPORT: begin
          // Cooldown only gates the reported bounce; raw contacts still publish.
          if ((r_cd == '0) && r_any) begin
            paddle_hit <= 1'b1;
            flip_x     <= 1'b1;
            r_cd       <= c_CD;
          end else begin
            paddle_hit <= 1'b0;
            flip_x     <= 1'b0;
            if (r_cd != '0) begin
              r_cd <= r_cd - CD_W'(1);
            end
          end
          paddle_idx   <= r_cand;
          touching     <= r_touch_acc;
          wall_top     <= r_wall_acc[3];
          wall_bottom  <= r_wall_acc[2];
          goal_left    <= r_wall_acc[1];
          goal_right   <= r_wall_acc[0];
          flip_y       <= r_wall_acc[3] | r_wall_acc[2];
          result_valid <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
